// File: rtl/pc_pkg.sv
// Shared types and defaults for the riscv16 fetch-stage program counter.
package pc_pkg;

  localparam int XLEN_DEF = 16;
  localparam logic [XLEN_DEF-1:0] RESET_VEC_DEF = 16'h0000;

  typedef enum logic [2:0] {
    PC_SEQ,
    PC_JUMP,
    PC_CALL,
    PC_RET,
    PC_REDIRECT,
    PC_HOLD
  } pc_sel_t;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack.
// A push when full overwrites the oldest entry.
module ras_stack
  import pc_pkg::*;
#(
  parameter int XLEN      = XLEN_DEF,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic            replace,
  input  logic [XLEN-1:0] din,
  output logic [XLEN-1:0] top,
  output logic            empty,
  output logic            full
);

  localparam int AW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);
  localparam logic [CW-1:0] MAXC = CW'(RAS_DEPTH);

  logic [XLEN-1:0] mem [RAS_DEPTH];
  logic [AW-1:0]   sp, sp_n, tp;
  logic [CW-1:0]   cnt, cnt_n;

  // sp points at the next free slot; wraps onto the oldest entry when full
  assign tp  = sp - 1'b1;
  assign top = mem[tp];

  always_comb begin
    sp_n  = sp;
    cnt_n = cnt;
    if (push) begin
      sp_n  = sp + 1'b1;
      cnt_n = (cnt == MAXC) ? cnt : cnt + 1'b1;
    end else if (pop && cnt != '0) begin
      sp_n  = tp;
      cnt_n = cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp    <= '0;
      cnt   <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
    end else begin
      sp    <= sp_n;
      cnt   <= cnt_n;
      empty <= (cnt_n == '0);
      full  <= (cnt_n == MAXC);
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[sp] <= din;
    else if (replace && cnt != '0)
      mem[tp] <= din;
  end

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter with redirect, stall,
// jumps and call/return through a return-address stack.
module pc_unit
  import pc_pkg::*;
#(
  parameter int              XLEN      = XLEN_DEF,
  parameter int              INC       = 1,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(RESET_VEC_DEF),
  parameter int              RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            jump,
  input  logic            call,
  input  logic            ret,
  input  logic [XLEN-1:0] target,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus,
  output logic            pc_valid,
  output logic            ras_empty,
  output logic            ras_full,
  output logic            ras_underflow
);

  pc_sel_t         sel;
  logic [XLEN-1:0] pc_n;
  logic [XLEN-1:0] ras_top;
  logic            push, pop, repl, unf_n;

  assign pc_plus = pc + XLEN'(INC);

  always_comb begin
    sel = PC_SEQ;
    if (redirect)
      sel = PC_REDIRECT;
    else if (stall)
      sel = PC_HOLD;
    else if (call && ret && !ras_empty)
      sel = PC_RET;
    else if (call)
      sel = PC_CALL;
    else if (ret)
      sel = PC_RET;
    else if (jump)
      sel = PC_JUMP;
  end

  // call+ret with a live top swaps the top entry instead of popping
  assign push  = (sel == PC_CALL);
  assign repl  = (sel == PC_RET) && call;
  assign pop   = (sel == PC_RET) && !call;
  assign unf_n = (sel == PC_RET) && ras_empty;

  always_comb begin
    pc_n = pc_plus;
    case (sel)
      PC_REDIRECT: pc_n = redirect_pc;
      PC_HOLD:     pc_n = pc;
      PC_CALL:     pc_n = target;
      PC_RET:      pc_n = ras_empty ? target : ras_top;
      PC_JUMP:     pc_n = target;
      default:     pc_n = pc_plus;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc            <= RESET_VEC;
      pc_valid      <= 1'b0;
      ras_underflow <= 1'b0;
    end else begin
      pc            <= pc_n;
      pc_valid      <= 1'b1;
      ras_underflow <= unf_n;
    end
  end

  ras_stack #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .replace (repl),
    .din     (pc_plus),
    .top     (ras_top),
    .empty   (ras_empty),
    .full    (ras_full)
  );

endmodule

// File: tb/tb_pc_unit.sv
// Directed checks of pc_unit: reset, wrap, call/return,
// RAS overflow/underflow and control priority.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst, stall, redirect, jump, call, ret;
  logic [15:0] redirect_pc, target;

  logic [15:0] pc1, pcp1, pc2, pcp2;
  logic        v1, e1, f1, u1;
  logic        v2, e2, f2, u2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pc_unit #(.XLEN(16), .INC(1), .RESET_VEC(16'h0000), .RAS_DEPTH(4)) dut1 (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .jump(jump), .call(call), .ret(ret),
    .target(target), .pc(pc1), .pc_plus(pcp1), .pc_valid(v1),
    .ras_empty(e1), .ras_full(f1), .ras_underflow(u1)
  );

  pc_unit #(.XLEN(16), .INC(2), .RESET_VEC(16'h0000), .RAS_DEPTH(4)) dut2 (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .jump(jump), .call(call), .ret(ret),
    .target(target), .pc(pc2), .pc_plus(pcp2), .pc_valid(v2),
    .ras_empty(e2), .ras_full(f2), .ras_underflow(u2)
  );

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 0; redirect = 0; jump = 0; call = 0; ret = 0;
  endtask

  initial begin
    rst = 1; idle(); redirect_pc = '0; target = '0;
    step(); step();
    chk("rst_pc", pc1, 16'h0000);
    chk("rst_valid", {15'b0, v1}, 16'h0);
    chk("rst_empty", {15'b0, e1}, 16'h1);
    chk("rst_full", {15'b0, f1}, 16'h0);
    #2 rst = 0;

    // test 1: run to 0042 with a live RAS entry, then async reset
    redirect = 1; redirect_pc = 16'h0042; step();
    chk("t1_redir", pc1, 16'h0042);
    chk("t1_valid", {15'b0, v1}, 16'h1);
    redirect = 0; call = 1; target = 16'h0080; step();
    chk("t1_call", pc1, 16'h0080);
    chk("t1_nempty", {15'b0, e1}, 16'h0);
    idle(); rst = 1; #1;
    chk("t1_async_pc", pc1, 16'h0000);
    chk("t1_async_valid", {15'b0, v1}, 16'h0);
    chk("t1_async_empty", {15'b0, e1}, 16'h1);
    chk("t1_async_unf", {15'b0, u1}, 16'h0);
    #2 rst = 0;
    step(); chk("t1_seq1", pc1, 16'h0001);
    chk("t1_seq1_valid", {15'b0, v1}, 16'h1);
    step(); chk("t1_seq2", pc1, 16'h0002);
    step(); chk("t1_seq3", pc1, 16'h0003);

    // test 2: wrap for INC=1 and INC=2
    redirect = 1; redirect_pc = 16'hFFFF; step();
    chk("t2_ffff", pc1, 16'hFFFF);
    chk("t2_plus", pcp1, 16'h0000);
    redirect = 0; step();
    chk("t2_wrap", pc1, 16'h0000);
    step(); chk("t2_after", pc1, 16'h0001);
    redirect = 1; redirect_pc = 16'hFFFE; step();
    chk("t2_inc2_fffe", pc2, 16'hFFFE);
    chk("t2_inc2_plus", pcp2, 16'h0000);
    redirect = 0; step();
    chk("t2_inc2_wrap", pc2, 16'h0000);

    // test 3: call then return
    redirect = 1; redirect_pc = 16'h0010; step();
    redirect = 0; call = 1; target = 16'h0100; step();
    chk("t3_call", pc1, 16'h0100);
    chk("t3_nempty", {15'b0, e1}, 16'h0);
    call = 0; step(); chk("t3_seq1", pc1, 16'h0101);
    step(); chk("t3_seq2", pc1, 16'h0102);
    ret = 1; step();
    chk("t3_ret", pc1, 16'h0011);
    chk("t3_empty", {15'b0, e1}, 16'h1);
    chk("t3_nounf", {15'b0, u1}, 16'h0);
    ret = 0;

    // test 4: overflow with five calls, then underflow on fifth ret
    redirect = 1; redirect_pc = 16'h0010; step();
    redirect = 0; call = 1;
    for (int i = 2; i <= 6; i++) begin
      target = 16'(i * 16);
      step();
      chk("t4_call", pc1, 16'(i * 16));
    end
    chk("t4_full", {15'b0, f1}, 16'h1);
    call = 0; ret = 1; target = 16'h0AAA;
    step(); chk("t4_ret1", pc1, 16'h0051);
    chk("t4_notfull", {15'b0, f1}, 16'h0);
    step(); chk("t4_ret2", pc1, 16'h0041);
    step(); chk("t4_ret3", pc1, 16'h0031);
    step(); chk("t4_ret4", pc1, 16'h0021);
    chk("t4_empty", {15'b0, e1}, 16'h1);
    chk("t4_unf0", {15'b0, u1}, 16'h0);
    step(); chk("t4_ret5", pc1, 16'h0AAA);
    chk("t4_unf1", {15'b0, u1}, 16'h1);
    chk("t4_empty5", {15'b0, e1}, 16'h1);
    ret = 0; step();
    chk("t4_unf_clr", {15'b0, u1}, 16'h0);
    chk("t4_seq", pc1, 16'h0AAB);

    // test 5: stall, redirect over stall, call beats jump
    stall = 1; jump = 1; target = 16'h0200;
    step(); chk("t5_stall1", pc1, 16'h0AAB);
    step(); chk("t5_stall2", pc1, 16'h0AAB);
    redirect = 1; redirect_pc = 16'h0300; step();
    chk("t5_redir", pc1, 16'h0300);
    idle(); call = 1; jump = 1; target = 16'h0400; step();
    chk("t5_calljump", pc1, 16'h0400);
    chk("t5_pushed", {15'b0, e1}, 16'h0);
    idle(); ret = 1; step();
    chk("t5_ret", pc1, 16'h0301);
    idle();

    // test 6: call+ret swaps the top entry
    redirect = 1; redirect_pc = 16'h0010; step();
    redirect = 0; call = 1; target = 16'h0100; step();
    chk("t6_call", pc1, 16'h0100);
    ret = 1; target = 16'h0200; step();
    chk("t6_swap_pc", pc1, 16'h0011);
    chk("t6_count", {15'b0, e1}, 16'h0);
    chk("t6_nfull", {15'b0, f1}, 16'h0);
    call = 0; step();
    chk("t6_new_top", pc1, 16'h0101);
    chk("t6_empty", {15'b0, e1}, 16'h1);
    idle(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
Parametrised program-counter unit for the riscv16 fetch stage. It replaces the fixed 16-bit increment-only counter and supports:
- configurable address width and increment
- a reset vector
- stall
- pipeline redirect (mispredict/trap)
- direct jumps
- call/return through a small circular return-address stack (RAS)

It sits between the next-PC control from decode/execute and the instruction-memory address port.

Parameters:
XLEN, 16, PC/address width in bits
INC, 1, sequential increment (1 = word-addressed memory, 2 = byte-addressed 16-bit instructions)
RESET_VEC, 16'h0000, PC value loaded during reset (XLEN bits)
RAS_DEPTH, 4, return-address stack entries (power of two, >= 2)

Ports:
clk  input  1  clock, rising-edge
rst  input  1  asynchronous active-high reset
stall  input  1  hold PC and RAS this cycle
redirect  input  1  flush/redirect request from execute or trap logic
redirect_pc  input  XLEN  redirect destination
jump  input  1  unconditional direct jump
call  input  1  jump and push return address
ret  input  1  return: pop RAS
target  input  XLEN  destination for jump/call, fallback for ret on underflow
pc  output  XLEN  current fetch address
pc_plus  output  XLEN  pc + INC (combinational, modulo 2^XLEN)
pc_valid  output  1  fetch address valid
ras_empty  output  1  RAS holds no entries
ras_full  output  1  RAS holds RAS_DEPTH entries
ras_underflow  output  1  one-cycle pulse: ret executed with empty RAS

Behaviour:
- Reset is asynchronous and active-high.
  - While rst=1: pc=RESET_VEC, pc_valid=0, RAS count=0, ras_empty=1, ras_full=0, ras_underflow=0.
  - pc_valid goes to 1 on the first rising edge after rst deasserts and stays 1.
- Reset mid-operation discards all RAS contents immediately, with no clock needed.
- One update per rising edge. Priority, highest first:
  1. redirect: pc<=redirect_pc. RAS unchanged. Takes effect even when stall=1 (a flush overrides a stall).
  2. stall: pc, RAS and count held. jump/call/ret are ignored, not queued.
  3. call and ret both asserted: pc<=RAS top, and the top entry is overwritten with pc_plus. Count unchanged. If the RAS is empty, behave as call alone.
  4. call: push pc_plus, pc<=target.
  5. ret: if not empty, pc<=top and pop. If empty, pc<=target, count stays 0, and ras_underflow pulses for one cycle.
  6. jump: pc<=target.
  7. otherwise: pc<=pc_plus.
- Simultaneous jump with call or ret: call/ret wins and jump is ignored.
- Arithmetic: pc_plus = pc + INC, truncated to XLEN bits. The all-ones address wraps to INC-1, with no flag raised.
- RAS is circular:
  - Push on full overwrites the oldest entry. Count saturates at RAS_DEPTH and ras_full stays 1.
  - Pop decrements count. ras_empty=1 when count=0.
  - Flags are registered, consistent with count after each edge.
- ras_underflow is registered and is 0 in any cycle without an underflowing ret.
- No combinational path from control inputs to pc. pc is always a register output.

Decomposition:
- Package pc_pkg holds:
  - default XLEN
  - RESET_VEC default
  - pc_sel_t enum: PC_SEQ, PC_JUMP, PC_CALL, PC_RET, PC_REDIRECT, PC_HOLD
- pc_unit contains the priority encoder that produces pc_sel_t, plus the PC register.
- One sub-module, ras_stack: parametrised circular LIFO (XLEN, RAS_DEPTH) with push, pop, replace, top, empty, full and async reset. Expected size about 80 lines, leaving pc_unit about 120 lines.

Test Plan:
1. Reset/sequential: assert rst mid-run with pc=16'h0042 -> pc=16'h0000 immediately, pc_valid=0. Release, run 3 clocks with no control -> pc=0001, 0002, 0003, pc_valid=1 from first edge.
2. Wrap: redirect to 16'hFFFF, then 2 idle clocks, INC=1 -> pc=FFFF, 0000, 0001. Repeat with INC=2, redirect to 16'hFFFE -> next pc=0000.
3. Call/return: at pc=0010 call target=0100 -> pc=0100, ras_empty=0. Two idle clocks -> 0101, 0102. ret -> pc=0011, ras_empty=1.
4. RAS overflow/underflow, RAS_DEPTH=4: five nested calls from pcs 0010,0020,0030,0040,0050 -> ras_full=1. Five rets with target=0AAA -> pc=0051, 0041, 0031, 0021, then 0AAA with ras_underflow pulse on the fifth.
5. Priority: stall=1 with jump target=0200 for 2 cycles -> pc held. stall=1 with redirect_pc=0300 -> pc=0300. call+jump together -> call taken, jump ignored.
6. call+ret together with top=0011 at pc=0100 -> pc=0011, top becomes 0101, count unchanged.
